// File: rtl/mapreduce_job_ctrl_pkg.sv
// Shared types and helpers for the MapReduce point-counting job sequencer.
package mapreduce_pkg;

  // Width of the accumulator total, shared with the reduce-count datapath.
  localparam int SUM_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLEAR    = 3'd1,
    DISPATCH = 3'd2,
    WAIT     = 3'd3,
    NEXT     = 3'd4,
    FINISH   = 3'd5,
    ERR      = 3'd6
  } state_e;

  // Ceiling log2; clog2(1) == 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int width_of(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/mapreduce_job_ctrl_if.sv
// Job-control bus between the sequencer (master) and the mapper/accumulator side (slave).
interface mapreduce_job_ctrl_if #(
  parameter int NUM_PTS   = 3,
  parameter int NUM_ITERS = 4
);
  import mapreduce_pkg::*;

  localparam int PT_W   = width_of(NUM_PTS);
  localparam int ITER_W = width_of(NUM_ITERS);

  logic              i_start;
  logic              i_abort;
  logic              o_busy;
  logic              o_acc_res;
  logic              i_acc_done;
  logic              o_pt_valid;
  logic              i_pt_ready;
  logic [PT_W-1:0]   o_pt_idx;
  logic              o_pt_last;
  logic [ITER_W-1:0] o_iter;
  logic              o_iter_done;
  logic              o_job_done;
  logic              o_timeout;

  modport master (
    input  i_start, i_abort, i_acc_done, i_pt_ready,
    output o_busy, o_acc_res, o_pt_valid, o_pt_idx, o_pt_last,
           o_iter, o_iter_done, o_job_done, o_timeout
  );

  modport slave (
    output i_start, i_abort, i_acc_done, i_pt_ready,
    input  o_busy, o_acc_res, o_pt_valid, o_pt_idx, o_pt_last,
           o_iter, o_iter_done, o_job_done, o_timeout
  );

endinterface

// File: rtl/mapreduce_job_ctrl_watchdog.sv
// Loadable down-counter that reports expiry when it reaches zero.
module mr_watchdog #(
  parameter int CNT_W = 10
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear beats load beats decrement; the counter parks at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/mapreduce_job_ctrl.sv
// Job sequencer: clears the accumulator, streams point indices to the mapper,
// waits for the accumulator's done flag, repeats per iteration, flags timeouts.
module mapreduce_job_ctrl #(
  parameter int NUM_OF_REDUCERS = 2,
  parameter int NUM_PTS         = 3,
  parameter int NUM_ITERS       = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input logic                  clock,
  input logic                  reset_n,
  mapreduce_job_ctrl_if.master bus
);
  import mapreduce_pkg::*;

  localparam int PT_W   = width_of(NUM_PTS);
  localparam int ITER_W = width_of(NUM_ITERS);
  localparam int CLR_W  = width_of(NUM_OF_REDUCERS);
  localparam int WD_W   = width_of(TIMEOUT_CYCLES);

  localparam logic [PT_W-1:0]   PT_LAST   = PT_W'(NUM_PTS - 1);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(NUM_ITERS - 1);
  localparam logic [CLR_W-1:0]  CLR_LAST  = CLR_W'(NUM_OF_REDUCERS - 1);
  // Loaded on the way into WAIT so expiry lands on the TIMEOUT_CYCLES-th WAIT cycle.
  localparam logic [WD_W-1:0]   WD_LOAD   = WD_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CLR_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic [PT_W-1:0]   pt_idx_q, pt_idx_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              timeout_q, timeout_d;
  logic              busy_q, busy_d;
  logic              acc_res_q, acc_res_d;
  logic              pt_valid_q, pt_valid_d;
  logic              pt_last_q, pt_last_d;
  logic              iter_done_q, iter_done_d;
  logic              job_done_q, job_done_d;

  logic              xfer;
  logic              wd_clr;
  logic              wd_load;
  logic              wd_en;
  logic              wd_expired;

  assign xfer = pt_valid_q && bus.i_pt_ready;

  // The watchdog is armed during DISPATCH and only counts while in WAIT.
  assign wd_clr  = (state_q != DISPATCH) && (state_q != WAIT);
  assign wd_load = (state_q == DISPATCH);
  assign wd_en   = (state_q == WAIT);

  mr_watchdog #(
    .CNT_W (WD_W)
  ) u_watchdog (
    .clock      (clock),
    .reset_n    (reset_n),
    .clr_i      (wd_clr),
    .load_i     (wd_load),
    .en_i       (wd_en),
    .load_val_i (WD_LOAD),
    .expired_o  (wd_expired)
  );

  // Next-state selection; abort overrides every transition out of a busy state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (bus.i_start) state_d = CLEAR;
      CLEAR:    if (clr_cnt_q == CLR_LAST) state_d = DISPATCH;
      DISPATCH: if (xfer && (pt_idx_q == PT_LAST)) state_d = WAIT;
      WAIT: begin
        if (bus.i_acc_done) begin
          state_d = NEXT;
        end else if (wd_expired) begin
          state_d = ERR;
        end
      end
      NEXT:     state_d = (iter_q == ITER_LAST) ? FINISH : CLEAR;
      FINISH:   state_d = IDLE;
      ERR:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (bus.i_abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end
  end

  // Counters, sticky error and registered output values derived from the next state.
  always_comb begin
    clr_cnt_d = '0;
    if ((state_q == CLEAR) && (state_d == CLEAR)) begin
      clr_cnt_d = clr_cnt_q + CLR_W'(1);
    end

    pt_idx_d = '0;
    if (state_q == DISPATCH) begin
      pt_idx_d = pt_idx_q;
      if (xfer && (pt_idx_q != PT_LAST)) begin
        pt_idx_d = pt_idx_q + PT_W'(1);
      end
    end

    iter_d    = iter_q;
    timeout_d = timeout_q;
    if ((state_q == IDLE) && bus.i_start) begin
      iter_d    = '0;
      timeout_d = 1'b0;
    end
    if ((state_q == NEXT) && (state_d == CLEAR)) begin
      iter_d = iter_q + ITER_W'(1);
    end
    if (state_d == ERR) begin
      timeout_d = 1'b1;
    end

    busy_d      = (state_d != IDLE);
    acc_res_d   = (state_d == CLEAR);
    pt_valid_d  = (state_d == DISPATCH);
    pt_last_d   = (state_d == DISPATCH) && (pt_idx_d == PT_LAST);
    iter_done_d = (state_d == NEXT);
    job_done_d  = (state_d == FINISH);
  end

  // State, counter and output registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      clr_cnt_q   <= '0;
      pt_idx_q    <= '0;
      iter_q      <= '0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
      acc_res_q   <= 1'b0;
      pt_valid_q  <= 1'b0;
      pt_last_q   <= 1'b0;
      iter_done_q <= 1'b0;
      job_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      pt_idx_q    <= pt_idx_d;
      iter_q      <= iter_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
      acc_res_q   <= acc_res_d;
      pt_valid_q  <= pt_valid_d;
      pt_last_q   <= pt_last_d;
      iter_done_q <= iter_done_d;
      job_done_q  <= job_done_d;
    end
  end

  assign bus.o_busy      = busy_q;
  assign bus.o_acc_res   = acc_res_q;
  assign bus.o_pt_valid  = pt_valid_q;
  assign bus.o_pt_idx    = pt_idx_q;
  assign bus.o_pt_last   = pt_last_q;
  assign bus.o_iter      = iter_q;
  assign bus.o_iter_done = iter_done_q;
  assign bus.o_job_done  = job_done_q;
  assign bus.o_timeout   = timeout_q;

endmodule

// File: tb/tb_mapreduce_job_ctrl.sv
// Scoreboard bench for mapreduce_job_ctrl (3 points, 2 iterations, 2 reducers, timeout 8).
module tb_mapreduce_job_ctrl;

  localparam int NPTS  = 3;
  localparam int NITER = 2;
  localparam int JOB   = 100;  // event code for a job-done pulse

  typedef struct {
    int idx;
    int last;
    int iter;
  } pt_exp_t;

  logic clock;
  logic reset_n;

  mapreduce_job_ctrl_if #(.NUM_PTS(NPTS), .NUM_ITERS(NITER)) bus();

  mapreduce_job_ctrl #(
    .NUM_OF_REDUCERS (2),
    .NUM_PTS         (NPTS),
    .NUM_ITERS       (NITER),
    .TIMEOUT_CYCLES  (8)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int      checks = 0;
  int      errors = 0;
  pt_exp_t exp_pt_q[$];
  int      exp_evt_q[$];
  int      acc_cnt = 0;
  int      valid_cnt = 0;
  int      base_acc;
  int      base_valid;
  logic    prev_stall = 1'b0;
  int      prev_idx = 0;
  int      prev_last = 0;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endfunction

  function automatic void push_pt(input int idx, input int last, input int iter);
    pt_exp_t e;
    e.idx = idx; e.last = last; e.iter = iter;
    exp_pt_q.push_back(e);
  endfunction

  // Hand-written vectors for one iteration: indices 0,1,2 with last on 2.
  function automatic void push_iter(input int iter);
    push_pt(0, 0, iter);
    push_pt(1, 0, iter);
    push_pt(2, 1, iter);
  endfunction

  function automatic void push_job();
    push_iter(0); exp_evt_q.push_back(0);
    push_iter(1); exp_evt_q.push_back(1);
    exp_evt_q.push_back(JOB);
  endfunction

  // Monitor: pops expectations for every transfer and every pulse the DUT shows.
  always @(negedge clock) begin
    pt_exp_t e;
    int ev;
    if (reset_n) begin
      if (bus.o_acc_res) acc_cnt++;
      if (bus.o_pt_valid) valid_cnt++;
      if (prev_stall && bus.o_pt_valid) begin
        chk("stall_idx_hold", int'(bus.o_pt_idx), prev_idx);
        chk("stall_last_hold", int'(bus.o_pt_last), prev_last);
      end
      if (bus.o_pt_valid && bus.i_pt_ready) begin
        if (exp_pt_q.size() == 0) begin
          chk("pt_unexpected", int'(bus.o_pt_idx), -1);
        end else begin
          e = exp_pt_q.pop_front();
          chk("pt_idx", int'(bus.o_pt_idx), e.idx);
          chk("pt_last", int'(bus.o_pt_last), e.last);
          chk("pt_iter", int'(bus.o_iter), e.iter);
        end
      end
      if (bus.o_iter_done) begin
        if (exp_evt_q.size() == 0) chk("iter_done_unexpected", int'(bus.o_iter), -1);
        else begin
          ev = exp_evt_q.pop_front();
          chk("iter_done_evt", int'(bus.o_iter), ev);
        end
      end
      if (bus.o_job_done) begin
        if (exp_evt_q.size() == 0) chk("job_done_unexpected", 1, 0);
        else begin
          ev = exp_evt_q.pop_front();
          chk("job_done_evt", JOB, ev);
        end
      end
    end
    prev_stall = bus.o_pt_valid && !bus.i_pt_ready;
    prev_idx   = int'(bus.o_pt_idx);
    prev_last  = int'(bus.o_pt_last);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Returns one step after the edge that transfers the final index (first WAIT cycle).
  task automatic wait_last_xfer();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      if (bus.o_pt_valid && bus.i_pt_ready && bus.o_pt_last) begin
        ok = 1'b1;
        break;
      end
    end
    chk("last_xfer_seen", int'(ok), 1);
    @(posedge clock);
    #1;
  endtask

  // Answer one iteration with done three cycles after its last transfer.
  task automatic serve_done();
    wait_last_xfer();
    tick(2);
    bus.i_acc_done = 1'b1;
    tick(1);
    bus.i_acc_done = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      if (!bus.o_busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_reached", int'(ok), 1);
    chk("pt_queue_empty", exp_pt_q.size(), 0);
    chk("evt_queue_empty", exp_evt_q.size(), 0);
    @(posedge clock);
    #1;
  endtask

  task automatic start_pulse();
    bus.i_start = 1'b1;
    tick(1);
    bus.i_start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, int'(bus.o_busy), 0);
    chk({tag, "_acc_res"}, int'(bus.o_acc_res), 0);
    chk({tag, "_pt_valid"}, int'(bus.o_pt_valid), 0);
    chk({tag, "_pt_idx"}, int'(bus.o_pt_idx), 0);
    chk({tag, "_pt_last"}, int'(bus.o_pt_last), 0);
    chk({tag, "_iter"}, int'(bus.o_iter), 0);
    chk({tag, "_iter_done"}, int'(bus.o_iter_done), 0);
    chk({tag, "_job_done"}, int'(bus.o_job_done), 0);
    chk({tag, "_timeout"}, int'(bus.o_timeout), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_time_limit actual=expired required=finish");
    $fatal(1, "time limit");
  end

  initial begin
    bit found;
    reset_n = 1'b0;
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    bus.i_acc_done = 1'b0;
    bus.i_pt_ready = 1'b1;
    tick(2);
    chk_all_zero("reset");
    reset_n = 1'b1;
    tick(1);

    // Nominal job: latency, clear length, index order, pulses and counts.
    base_acc = acc_cnt;
    base_valid = valid_cnt;
    push_job();
    start_pulse();
    chk("t1_busy_clear", int'(bus.o_busy), 1);
    chk("t1_acc_res_c1", int'(bus.o_acc_res), 1);
    chk("t1_valid_c1", int'(bus.o_pt_valid), 0);
    tick(1);
    chk("t1_acc_res_c2", int'(bus.o_acc_res), 1);
    chk("t1_valid_c2", int'(bus.o_pt_valid), 0);
    tick(1);
    chk("t1_valid_c3", int'(bus.o_pt_valid), 1);
    chk("t1_acc_res_c3", int'(bus.o_acc_res), 0);
    serve_done();
    serve_done();
    wait_idle();
    chk("t1_acc_res_cycles", acc_cnt - base_acc, 4);
    chk("t1_valid_cycles", valid_cnt - base_valid, 6);

    // Backpressure: ready low for four cycles while index 1 is offered.
    push_job();
    start_pulse();
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus.o_pt_valid) begin
        found = 1'b1;
        break;
      end
      tick(1);
    end
    chk("t2_valid_seen", int'(found), 1);
    tick(1);
    bus.i_pt_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("t2_stall_idx", int'(bus.o_pt_idx), 1);
      chk("t2_stall_last", int'(bus.o_pt_last), 0);
      tick(1);
    end
    bus.i_pt_ready = 1'b1;
    serve_done();
    serve_done();
    wait_idle();

    // Watchdog: done never arrives, eight WAIT cycles then ERR then IDLE.
    push_iter(0);
    start_pulse();
    wait_last_xfer();
    tick(7);
    chk("t3_timeout_before", int'(bus.o_timeout), 0);
    chk("t3_busy_wait7", int'(bus.o_busy), 1);
    tick(1);
    chk("t3_timeout_err", int'(bus.o_timeout), 1);
    chk("t3_busy_err", int'(bus.o_busy), 1);
    chk("t3_job_done_err", int'(bus.o_job_done), 0);
    tick(1);
    chk("t3_busy_idle", int'(bus.o_busy), 0);
    chk("t3_timeout_sticky", int'(bus.o_timeout), 1);
    chk("t3_pt_queue_empty", exp_pt_q.size(), 0);

    // Abort at index 1 of iteration 1 (that transfer is accepted), then restart.
    push_iter(0);
    exp_evt_q.push_back(0);
    push_pt(0, 0, 1);
    push_pt(1, 0, 1);
    start_pulse();
    chk("t4_start_clears_timeout", int'(bus.o_timeout), 0);
    serve_done();
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.o_pt_valid && (bus.o_pt_idx == 1) && (bus.o_iter == 1)) begin
        found = 1'b1;
        break;
      end
      tick(1);
    end
    chk("t4_abort_point_seen", int'(found), 1);
    bus.i_abort = 1'b1;
    tick(1);
    bus.i_abort = 1'b0;
    chk("t4_abort_busy", int'(bus.o_busy), 0);
    chk("t4_abort_valid", int'(bus.o_pt_valid), 0);
    chk("t4_abort_acc_res", int'(bus.o_acc_res), 0);
    chk("t4_abort_pt_queue", exp_pt_q.size(), 0);
    push_job();
    start_pulse();
    chk("t4_restart_iter", int'(bus.o_iter), 0);
    serve_done();
    serve_done();
    wait_idle();

    // Premature done in CLEAR/DISPATCH and start held while busy are ignored.
    push_job();
    bus.i_start = 1'b1;
    tick(1);
    bus.i_acc_done = 1'b1;
    wait_last_xfer();
    bus.i_acc_done = 1'b0;
    tick(3);
    chk("t5_still_busy", int'(bus.o_busy), 1);
    chk("t5_no_iter_done", int'(bus.o_iter_done), 0);
    chk("t5_no_valid", int'(bus.o_pt_valid), 0);
    bus.i_start = 1'b0;
    bus.i_acc_done = 1'b1;
    tick(1);
    bus.i_acc_done = 1'b0;
    chk("t5_iter_done_now", int'(bus.o_iter_done), 1);
    serve_done();
    wait_idle();

    // Reset in WAIT clears everything; a later done does nothing.
    push_iter(0);
    start_pulse();
    wait_last_xfer();
    tick(2);
    reset_n = 1'b0;
    tick(1);
    chk_all_zero("t6_wait_reset");
    reset_n = 1'b1;
    tick(1);
    bus.i_acc_done = 1'b1;
    tick(1);
    bus.i_acc_done = 1'b0;
    tick(2);
    chk("t6_idle_after_done", int'(bus.o_busy), 0);

    // Reset while the sticky timeout is set.
    push_iter(0);
    start_pulse();
    wait_last_xfer();
    tick(8);
    chk("t6_timeout_set", int'(bus.o_timeout), 1);
    reset_n = 1'b0;
    tick(1);
    chk_all_zero("t6_err_reset");
    reset_n = 1'b1;
    tick(2);
    chk("t6_final_pt_queue", exp_pt_q.size(), 0);
    chk("t6_final_evt_queue", exp_evt_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mapreduce_job_ctrl.md
Name: mapreduce_job_ctrl

Overview:
Job sequencer for the MapReduce point-counting datapath. On a start request it clears the reduce-count accumulator, streams NUM_PTS point indices to the mapper front end over a valid/ready handshake, and waits for the accumulator's done flag. It repeats this for NUM_ITERS iterations, then reports job completion. A watchdog flags a timeout if the accumulator never reaches NUM_PTS.

Parameters:
NUM_OF_REDUCERS, 2, reducer count; sets the accumulator chain depth, which is used as the clear/drain length.
NUM_PTS, 3, points dispatched per iteration (>=1).
NUM_ITERS, 4, iterations per job (>=1).
TIMEOUT_CYCLES, 1024, maximum cycles in WAIT before error (>=2).

Ports:
clock  in  1  system clock, all logic on rising edge
reset_n  in  1  reset, synchronous, active-low
i_start  in  1  job start request; sampled only in IDLE
i_abort  in  1  synchronous abort, honoured in any state
o_busy  out  1  high in every state except IDLE
o_acc_res  out  1  clear to accumulator and reducers
i_acc_done  in  1  accumulator total == NUM_PTS
o_pt_valid  out  1  point index valid
i_pt_ready  in  1  mapper accepts point
o_pt_idx  out  PT_W  point index 0..NUM_PTS-1
o_pt_last  out  1  high with the final index of an iteration
o_iter  out  ITER_W  current iteration 0..NUM_ITERS-1
o_iter_done  out  1  one-cycle pulse per completed iteration
o_job_done  out  1  one-cycle pulse at job end
o_timeout  out  1  sticky error; cleared by the next accepted i_start

Behaviour:
- Widths: PT_W = max(1, clog2(NUM_PTS)); ITER_W = max(1, clog2(NUM_ITERS)).
- Reset (reset_n low at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0, including o_timeout.
  - All counters are cleared.
- States: IDLE, CLEAR, DISPATCH, WAIT, NEXT, FINISH, ERR.
- IDLE:
  - i_start=1 moves to CLEAR next cycle.
  - The same edge clears o_timeout, sets iter=0 and clears o_iter.
- CLEAR:
  - o_acc_res=1 for exactly NUM_OF_REDUCERS cycles, so the accumulator's adder chain drains stale partial sums.
  - Then moves to DISPATCH with pt_idx=0.
- DISPATCH:
  - o_pt_valid=1.
  - A transfer occurs on a cycle where o_pt_valid && i_pt_ready.
  - o_pt_idx and o_pt_last are held stable while valid && !ready.
  - o_pt_last = (o_pt_idx == NUM_PTS-1).
  - On a transfer of the last index: next state is WAIT, and o_pt_valid=0 the next cycle.
  - Otherwise pt_idx increments on each transfer.
  - Back-to-back transfers sustain one index per cycle.
- WAIT:
  - The watchdog counter is zeroed on entry and increments each cycle.
  - i_acc_done=1 moves to NEXT.
  - If the counter reaches TIMEOUT_CYCLES-1 with i_acc_done=0, move to ERR.
  - If done and the timeout limit occur in the same cycle, done wins.
  - i_acc_done is ignored outside WAIT; a premature done during CLEAR or DISPATCH has no effect.
- NEXT:
  - o_iter_done pulses for 1 cycle.
  - If iter == NUM_ITERS-1, move to FINISH.
  - Otherwise increment iter and o_iter, then move to CLEAR.
- FINISH: o_job_done pulses for 1 cycle, then IDLE.
- ERR: o_timeout set (sticky), then IDLE. o_job_done is not pulsed.
- i_abort:
  - In any non-IDLE state, the next state is IDLE.
  - o_pt_valid, o_acc_res, o_iter_done and o_job_done drop next cycle.
  - o_timeout is unchanged.
  - i_abort has priority over all transitions, including a completing handshake; a transfer in the abort cycle still counts as accepted by the mapper.
- i_start outside IDLE is ignored.
- Latency: start to first o_pt_valid = 1 + NUM_OF_REDUCERS cycles.
- All outputs are registered.

Decomposition:
- Shared package mapreduce_pkg holds:
  - state enum (IDLE..ERR)
  - the clog2 function
  - SUM_WIDTH=32 (shared with the accumulator)
- One natural sub-module: mr_watchdog, a loadable down-counter with clear/enable inputs and an expired output, used in WAIT.
- FSM, dispatch counter and iteration counter stay in the top module.

Test Plan:
1. NUM_PTS=3, NUM_ITERS=2, i_pt_ready=1, i_acc_done asserted 3 cycles after the last transfer:
   - o_acc_res high 2 cycles per iteration.
   - idx sequence 0,1,2 with last on 2.
   - o_iter_done pulses twice.
   - o_job_done one pulse; total o_pt_valid cycles = 6.
2. Ready backpressure: i_pt_ready low for 4 cycles while idx=1:
   - idx=1 and o_pt_last=0 held stable.
   - No skipped or duplicated index.
3. Done never arrives, TIMEOUT_CYCLES=8:
   - ERR reached after 8 WAIT cycles; o_timeout=1, o_job_done stays 0, then IDLE.
   - Next i_start clears o_timeout.
4. i_abort asserted mid-DISPATCH at idx=1:
   - IDLE next cycle, o_busy=0, o_pt_valid=0.
   - A new i_start restarts at iter 0, idx 0.
5. i_acc_done pulsed during CLEAR and DISPATCH, plus i_start held high while busy:
   - Both ignored; the FSM still waits in WAIT for a fresh done.
6. reset_n low during WAIT with o_timeout=1 from a prior job:
   - All outputs 0 after the edge, including o_timeout; state IDLE.
